detector_jogada: RTL and testbench

- Upstream stage of the 2-bit play register in the memory-game datapath.
- Debounces the four game buttons and encodes the single pressed button into a 2-bit code.
- Emits a one-cycle `registra` pulse that drives the register's enable; `codigo` drives its D input.
- Refuses simultaneous presses and waits for a debounced release before accepting the next play.

---
 rtl/detector_jogada_pkg.sv | 63 ++++++
 rtl/detector_jogada_if.sv | 29 ++
 rtl/detector_jogada_contador_debounce.sv | 54 +++++
 rtl/detector_jogada.sv | 152 +++++++++++++++
 tb/tb_detector_jogada.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/detector_jogada_pkg.sv
// -----------------------------------------------------------------------------
// detector_jogada_pkg
// Shared definitions for the play detector of the memory-game datapath:
//   - FSM state encodings (ESPERA / FILTRA / REGISTRA / SOLTA)
//   - button-to-code constants
//   - default debounce length
//   - small combinational helpers for encoding and press classification
// -----------------------------------------------------------------------------
package detector_jogada_pkg;

  // Default number of consecutive stable samples for press and release.
  localparam int DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    ESPERA   = 2'b00,  // idle, waiting for a single press
    FILTRA   = 2'b01,  // press seen, debouncing it
    REGISTRA = 2'b10,  // one-cycle registration pulse
    SOLTA    = 2'b11   // waiting for a debounced release
  } estado_t;

  // Code driven on codigo for each button.
  localparam logic [1:0] COD_BOTAO0 = 2'b00;
  localparam logic [1:0] COD_BOTAO1 = 2'b01;
  localparam logic [1:0] COD_BOTAO2 = 2'b10;
  localparam logic [1:0] COD_BOTAO3 = 2'b11;

  // Encode a one-hot button vector into its 2-bit play code.
  function automatic logic [1:0] codifica(input logic [3:0] botoes);
    logic [1:0] cod;
    case (botoes)
      4'b0001: cod = COD_BOTAO0;
      4'b0010: cod = COD_BOTAO1;
      4'b0100: cod = COD_BOTAO2;
      4'b1000: cod = COD_BOTAO3;
      default: cod = COD_BOTAO0;
    endcase
    return cod;
  endfunction

  // Rebuild the one-hot button vector that produced a code.
  function automatic logic [3:0] decodifica(input logic [1:0] cod);
    logic [3:0] botoes;
    case (cod)
      COD_BOTAO0: botoes = 4'b0001;
      COD_BOTAO1: botoes = 4'b0010;
      COD_BOTAO2: botoes = 4'b0100;
      COD_BOTAO3: botoes = 4'b1000;
      default:    botoes = 4'b0000;
    endcase
    return botoes;
  endfunction

  // True when exactly one button is pressed.
  function automatic logic eh_unico(input logic [3:0] botoes);
    return ($countones(botoes) == 32'd1);
  endfunction

  // True when two or more buttons are pressed.
  function automatic logic eh_multiplo(input logic [3:0] botoes);
    return ($countones(botoes) >= 32'd2);
  endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// -----------------------------------------------------------------------------
// detector_jogada_if
// Bundle between the game side (buttons + control unit) and the play detector.
//   enable        : new plays accepted
//   botoes[3:0]   : raw, pre-synchronised button levels (1 = pressed)
//   codigo[1:0]   : encoded play (D input of the play register)
//   registra      : one-cycle pulse, enable of the play register
//   erro_multiplo : two or more buttons pressed while idle
//   ocupado       : detector is not idle
// master = game side, slave = detector.
// -----------------------------------------------------------------------------
interface detector_jogada_if;
  logic       enable;
  logic [3:0] botoes;
  logic [1:0] codigo;
  logic       registra;
  logic       erro_multiplo;
  logic       ocupado;

  modport master (
    output enable, botoes,
    input  codigo, registra, erro_multiplo, ocupado
  );

  modport slave (
    input  enable, botoes,
    output codigo, registra, erro_multiplo, ocupado
  );
endinterface

// File: rtl/detector_jogada_contador_debounce.sv
// -----------------------------------------------------------------------------
// contador_debounce
// Mod-N up-counter shared by the press and release debounce phases.
//   clock   : rising-edge clock
//   clear_n : synchronous active-low reset
//   zera_i  : synchronous clear (wins over conta_i)
//   conta_i : count enable
//   fim_o   : terminal flag, high when counting on the last value (N-1)
// The counter wraps to zero on fim, so it never exceeds N-1.
// -----------------------------------------------------------------------------
module contador_debounce #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic clock,
  input  logic clear_n,
  input  logic zera_i,
  input  logic conta_i,
  output logic fim_o
);

  localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, then counting with wrap at N-1.
  always_comb begin
    cnt_d = cnt_q;
    if (zera_i) begin
      cnt_d = '0;
    end else if (conta_i) begin
      if (cnt_q == ULTIMO) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim_o = conta_i && (cnt_q == ULTIMO);

endmodule

// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
// Debounces the four game buttons, encodes a single pressed button into a
// 2-bit code and emits a one-cycle registra pulse for the play register.
// Simultaneous presses are refused; a debounced release is required before
// the next play is accepted.
//   clock   : system clock, rising edge
//   clear_n : synchronous active-low reset
//   bus     : detector_jogada_if.slave (enable, botoes in; codigo, registra,
//             erro_multiplo, ocupado out -- all outputs registered)
// -----------------------------------------------------------------------------
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input logic              clock,
  input logic              clear_n,
  detector_jogada_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  estado_t    estado_q;
  logic [1:0] codigo_q;
  logic       registra_q;
  logic       erro_multiplo_q;
  logic       ocupado_q;

  logic zera_s;
  logic conta_s;
  logic fim_s;
  logic confirma_s;
  logic livre_s;

  // Held buttons still match the latched play and plays are still allowed.
  assign confirma_s = bus.enable && (bus.botoes == decodifica(codigo_q));
  assign livre_s    = (bus.botoes == 4'b0000);

  contador_debounce #(
    .N  (DEBOUNCE_CYCLES),
    .CW (CW)
  ) u_contador (
    .clock   (clock),
    .clear_n (clear_n),
    .zera_i  (zera_s),
    .conta_i (conta_s),
    .fim_o   (fim_s)
  );

  // Counter control: count only while the debounced condition holds,
  // otherwise restart from zero.
  always_comb begin
    zera_s  = 1'b0;
    conta_s = 1'b0;
    case (estado_q)
      ESPERA: begin
        zera_s = 1'b1;
      end
      FILTRA: begin
        if (confirma_s) begin
          conta_s = 1'b1;
        end else begin
          zera_s = 1'b1;
        end
      end
      REGISTRA: begin
        zera_s = 1'b1;
      end
      SOLTA: begin
        if (livre_s) begin
          conta_s = 1'b1;
        end else begin
          zera_s = 1'b1;
        end
      end
      default: begin
        zera_s = 1'b1;
      end
    endcase
  end

  // Play FSM with registered outputs. Reset lands in SOLTA so a button held
  // through reset must be released before it can register.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      estado_q        <= SOLTA;
      codigo_q        <= COD_BOTAO0;
      registra_q      <= 1'b0;
      erro_multiplo_q <= 1'b0;
      ocupado_q       <= 1'b1;
    end else begin
      case (estado_q)
        ESPERA: begin
          registra_q <= 1'b0;
          if (bus.enable && eh_unico(bus.botoes)) begin
            codigo_q        <= codifica(bus.botoes);
            estado_q        <= FILTRA;
            erro_multiplo_q <= 1'b0;
            ocupado_q       <= 1'b1;
          end else if (bus.enable && eh_multiplo(bus.botoes)) begin
            erro_multiplo_q <= 1'b1;
          end else begin
            erro_multiplo_q <= 1'b0;
          end
        end
        FILTRA: begin
          erro_multiplo_q <= 1'b0;
          if (confirma_s) begin
            if (fim_s) begin
              estado_q   <= REGISTRA;
              registra_q <= 1'b1;
            end else begin
              registra_q <= 1'b0;
            end
          end else begin
            estado_q   <= ESPERA;
            registra_q <= 1'b0;
            ocupado_q  <= 1'b0;
          end
        end
        REGISTRA: begin
          estado_q        <= SOLTA;
          registra_q      <= 1'b0;
          erro_multiplo_q <= 1'b0;
        end
        SOLTA: begin
          registra_q      <= 1'b0;
          erro_multiplo_q <= 1'b0;
          if (livre_s && fim_s) begin
            estado_q  <= ESPERA;
            ocupado_q <= 1'b0;
          end else begin
            ocupado_q <= 1'b1;
          end
        end
        default: begin
          estado_q        <= SOLTA;
          registra_q      <= 1'b0;
          erro_multiplo_q <= 1'b0;
          ocupado_q       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.codigo        = codigo_q;
  assign bus.registra      = registra_q;
  assign bus.erro_multiplo = erro_multiplo_q;
  assign bus.ocupado       = ocupado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// -----------------------------------------------------------------------------
// tb_detector_jogada
// Directed bench for detector_jogada with DEBOUNCE_CYCLES = 4. Inputs change
// 1 ns after a rising edge; outputs are read at that same point, so each
// check sees the state produced by the edge just taken.
// -----------------------------------------------------------------------------
module tb_detector_jogada;

  logic clock;
  logic clear_n;
  int   errors;
  int   checks;
  int   pulsos;

  detector_jogada_if bus_if ();

  detector_jogada #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count registra pulses mid-cycle, one count per high cycle.
  always @(negedge clock) begin
    if (bus_if.registra === 1'b1) pulsos <= pulsos + 1;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Take n rising edges and settle 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Release all buttons and confirm idle after the 4-sample release filter.
  task automatic solta_e_espera(input string tag);
    bus_if.botoes = 4'b0000;
    step(3);
    check_eq({tag, "_ocup_hold"}, {7'd0, bus_if.ocupado}, 8'd1);
    step(1);
    check_eq({tag, "_ocup_free"}, {7'd0, bus_if.ocupado}, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    pulsos = 0;
    clear_n = 1'b0;
    bus_if.enable = 1'b1;
    bus_if.botoes = 4'b0000;

    // 1. Reset state and release filter out of reset.
    step(2);
    check_eq("rst_ocup", {7'd0, bus_if.ocupado}, 8'd1);
    check_eq("rst_reg",  {7'd0, bus_if.registra}, 8'd0);
    check_eq("rst_err",  {7'd0, bus_if.erro_multiplo}, 8'd0);
    check_eq("rst_cod",  {6'd0, bus_if.codigo}, 8'd0);
    clear_n = 1'b1;
    step(3);
    check_eq("rel_ocup3", {7'd0, bus_if.ocupado}, 8'd1);
    step(1);
    check_eq("rel_ocup4", {7'd0, bus_if.ocupado}, 8'd0);
    check_eq("rel_pulses", pulsos[7:0], 8'd0);

    // 2. Press button 2, held 10 cycles.
    bus_if.botoes = 4'b0100;
    step(1);
    check_eq("p2_cod",  {6'd0, bus_if.codigo}, 8'd2);
    check_eq("p2_ocup", {7'd0, bus_if.ocupado}, 8'd1);
    step(3);
    check_eq("p2_early", {7'd0, bus_if.registra}, 8'd0);
    step(1);
    check_eq("p2_pulse", {7'd0, bus_if.registra}, 8'd1);
    check_eq("p2_codp",  {6'd0, bus_if.codigo}, 8'd2);
    step(1);
    check_eq("p2_fall", {7'd0, bus_if.registra}, 8'd0);
    step(4);
    check_eq("p2_held_ocup", {7'd0, bus_if.ocupado}, 8'd1);
    check_eq("p2_once", pulsos[7:0], 8'd1);
    solta_e_espera("p2");

    // 3. Bounce: 2 cycles, gap, then 6 cycles of button 1.
    bus_if.botoes = 4'b0010;
    step(2);
    bus_if.botoes = 4'b0000;
    step(1);
    check_eq("bn_abort_ocup", {7'd0, bus_if.ocupado}, 8'd0);
    check_eq("bn_abort_pls", pulsos[7:0], 8'd1);
    bus_if.botoes = 4'b0010;
    step(4);
    check_eq("bn_early", {7'd0, bus_if.registra}, 8'd0);
    step(1);
    check_eq("bn_pulse", {7'd0, bus_if.registra}, 8'd1);
    check_eq("bn_cod",   {6'd0, bus_if.codigo}, 8'd1);
    step(1);
    solta_e_espera("bn");
    check_eq("bn_count", pulsos[7:0], 8'd2);

    // 4. Simultaneous press, then narrow to button 0.
    bus_if.botoes = 4'b1001;
    step(1);
    check_eq("mu_err",  {7'd0, bus_if.erro_multiplo}, 8'd1);
    check_eq("mu_ocup", {7'd0, bus_if.ocupado}, 8'd0);
    step(2);
    check_eq("mu_err_hold", {7'd0, bus_if.erro_multiplo}, 8'd1);
    check_eq("mu_noreg", {7'd0, bus_if.registra}, 8'd0);
    bus_if.botoes = 4'b0001;
    step(1);
    check_eq("mu_err_clr", {7'd0, bus_if.erro_multiplo}, 8'd0);
    check_eq("mu_cod",     {6'd0, bus_if.codigo}, 8'd0);
    step(3);
    check_eq("mu_early", {7'd0, bus_if.registra}, 8'd0);
    step(1);
    check_eq("mu_pulse", {7'd0, bus_if.registra}, 8'd1);
    step(1);
    solta_e_espera("mu");
    check_eq("mu_count", pulsos[7:0], 8'd3);

    // 5. enable low while button 3 is held in ESPERA.
    bus_if.enable = 1'b0;
    bus_if.botoes = 4'b1000;
    step(6);
    check_eq("en0_ocup", {7'd0, bus_if.ocupado}, 8'd0);
    check_eq("en0_cod",  {6'd0, bus_if.codigo}, 8'd0);
    check_eq("en0_pls",  pulsos[7:0], 8'd3);
    bus_if.botoes = 4'b0000;
    bus_if.enable = 1'b1;
    step(1);

    // 6. enable dropped mid-FILTRA.
    bus_if.botoes = 4'b1000;
    step(2);
    check_eq("enm_filtra", {7'd0, bus_if.ocupado}, 8'd1);
    check_eq("enm_cod",    {6'd0, bus_if.codigo}, 8'd3);
    bus_if.enable = 1'b0;
    step(1);
    check_eq("enm_abort", {7'd0, bus_if.ocupado}, 8'd0);
    step(4);
    check_eq("enm_pls", pulsos[7:0], 8'd3);
    bus_if.botoes = 4'b0000;
    bus_if.enable = 1'b1;
    step(1);

    // 7. Reset during FILTRA with button 3 held.
    bus_if.botoes = 4'b1000;
    step(2);
    clear_n = 1'b0;
    step(1);
    check_eq("rm_ocup", {7'd0, bus_if.ocupado}, 8'd1);
    check_eq("rm_cod",  {6'd0, bus_if.codigo}, 8'd0);
    clear_n = 1'b1;
    step(8);
    check_eq("rm_reg",  {7'd0, bus_if.registra}, 8'd0);
    check_eq("rm_busy", {7'd0, bus_if.ocupado}, 8'd1);
    check_eq("rm_pls",  pulsos[7:0], 8'd3);
    solta_e_espera("rm");
    bus_if.botoes = 4'b1000;
    step(4);
    check_eq("rm2_early", {7'd0, bus_if.registra}, 8'd0);
    step(1);
    check_eq("rm2_pulse", {7'd0, bus_if.registra}, 8'd1);
    check_eq("rm2_cod",   {6'd0, bus_if.codigo}, 8'd3);
    step(1);
    solta_e_espera("rm2");
    check_eq("final_pls", pulsos[7:0], 8'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
